repo_read_arbiter: RTL and testbench
====================================

Name: repo_read_arbiter

Overview:
- Shares one single-port, read-only task repository memory between N_REQ platform instances (HeMPS and Hybrid) that each fetch object code by byte address.
- Each requester asks for a burst of consecutive 32-bit words. The block grants requesters round-robin, issues pipelined reads to the memory and steers returned words back to the owner.
- Sits between the platform repository ports (mem_addr/data_read) and the shared repository memory.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- LEN_W, 8, width of burst-length field; max burst 2^LEN_W-1 words
- MEM_LAT, 2, memory read latency in cycles from mem_rd sample edge to mem_data valid (1..4)
- ADDR_W, 30, byte-address width

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req  in  N_REQ  per-requester read request; held high until done
- req_addr  in  N_REQ*ADDR_W  packed start byte addresses, word-aligned (bits[1:0] ignored)
- req_len  in  N_REQ*LEN_W  packed burst lengths in words; 0 treated as 1
- gnt  out  N_REQ  one-hot, high for the whole owned transaction
- rvalid  out  N_REQ  one-hot, marks rdata valid for that requester
- rdata  out  32  returned word, shared by all requesters
- done  out  N_REQ  one-cycle pulse after the owner's last word
- mem_addr  out  ADDR_W  memory byte address; word index = mem_addr[23:2]
- mem_rd  out  1  read strobe, one word per cycle
- mem_data  in  32  memory read data, valid MEM_LAT cycles after the mem_rd edge

Behaviour:
- Reset (reset=0, async): all outputs are 0; state=IDLE; rr_ptr=0; pending tag pipe cleared. In-flight data is discarded and produces no rvalid.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: if any req is high, select the winner with the round-robin search starting at rr_ptr. Latch its addr (bits[1:0] forced to 0) and len (0 becomes 1) into cur_addr and remaining. Go to ISSUE on the next cycle. With no req high, stay in IDLE.
- ISSUE: gnt[w]=1, mem_rd=1, mem_addr=cur_addr. Each cycle cur_addr += 4, wrapping modulo 2^ADDR_W, and remaining -= 1. When remaining reaches 1 at issue, go to DRAIN next cycle. Back-to-back issue, no bubbles.
- Tag pipe: a MEM_LAT-deep shift register records valid plus last-flag per issued read.
  - rvalid[w]=1 and rdata=mem_data exactly in the cycle the tag emerges: MEM_LAT cycles after the corresponding mem_rd cycle.
  - rdata is combinational from mem_data and 0 when no rvalid is high.
- DRAIN: mem_rd=0, gnt[w] stays high. Leave for DONE in the cycle the last-flagged tag emerges.
- DONE: done[w]=1 for exactly one cycle, gnt=0, rr_ptr=(w+1) mod N_REQ. Return to IDLE next cycle.
- Requester contract: it must deassert req in the cycle it sees done; a req still high in IDLE is treated as a new request.
- Latency, single-word request: req rises at edge T (IDLE) → ISSUE in T+1 with mem_rd → rvalid in T+1+MEM_LAT → done in T+2+MEM_LAT.
- Simultaneous requests: only one winner per arbitration; the others wait. Starvation bound is (N_REQ-1) bursts.
- req dropped mid-burst: ignored; the burst completes and done still pulses.
- req_addr/req_len changes after the grant: ignored (latched).
- Reset mid-burst: abort immediately; after release the block restarts in IDLE with rr_ptr=0.

Decomposition:
- Package hybrid_repo_pack holds:
  - constants REPO_WORD_W=32, REPO_ADDR_W=30, REPO_IDX_HI=23, REPO_IDX_LO=2;
  - typedef repo_state_t enum {IDLE, ISSUE, DRAIN, DONE};
  - typedef repo_tag_t struct {valid, last}.
- Sub-module rr_arbiter (N_REQ, combinational winner from req and rr_ptr, one-hot plus index outputs), reused by other shared-resource blocks.

Test Plan:
- Reset: hold reset=0 with req=2'b11 → gnt, rvalid, done, mem_rd all 0. Release, MEM_LAT=2: req[0], addr=0x100, len=1 → mem_rd one cycle with mem_addr=0x100, rvalid[0] 2 cycles later with rdata=mem[0x40], done[0] the following cycle.
- Burst: req[1], addr=0x200, len=4 → mem_addr 0x200/0x204/0x208/0x20C on 4 consecutive cycles. rvalid[1] on 4 consecutive cycles with words mem[0x80..0x83], then a single done[1] pulse.
- Contention: req=2'b11 from reset, len=2 each → requester 0 served first, then 1 (rr_ptr=1). req 0 re-asserted during the requester-1 burst is served only after done[1]. gnt never has 2 bits set.
- Wrap and alignment: addr=0x3FFFFFFE, len=2 → mem_addr 0x3FFFFFFC then 0x00000000. len=0 → exactly 1 word read.
- Abort: assert reset low during the 3rd word of a len=8 burst → outputs 0 immediately. No rvalid for in-flight reads after release. A new req[0] is served from IDLE.

Source files
------------

// File: rtl/repo_read_arbiter_pkg.sv
// Shared types and constants for the task-repository read arbiter.
// The repository is word-addressed internally; requesters use byte addresses.
package hybrid_repo_pack;
   localparam int REPO_WORD_W = 32;
   localparam int REPO_ADDR_W = 30;
   localparam int REPO_IDX_HI = 23;
   localparam int REPO_IDX_LO = 2;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} repo_state_t;

   typedef struct packed {
      logic valid;
      logic last;
   } repo_tag_t;
endpackage

// File: rtl/repo_read_arbiter_if.sv
// Requester and memory signals of the repository arbiter.
// The slave modport is the arbiter's view; master is the platform/memory side.
interface repo_read_arbiter_if
   import hybrid_repo_pack::*;
#(
   parameter int N_REQ  = 2,
   parameter int LEN_W  = 8,
   parameter int ADDR_W = REPO_ADDR_W
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*LEN_W-1:0]  req_len;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        rvalid;
   logic [REPO_WORD_W-1:0]  rdata;
   logic [N_REQ-1:0]        done;
   logic [ADDR_W-1:0]       mem_addr;
   logic                    mem_rd;
   logic [REPO_WORD_W-1:0]  mem_data;

   modport slave (
      input  req, req_addr, req_len, mem_data,
      output gnt, rvalid, rdata, done, mem_addr, mem_rd
   );

   modport master (
      output req, req_addr, req_len, mem_data,
      input  gnt, rvalid, rdata, done, mem_addr, mem_rd
   );
endinterface

// File: rtl/repo_read_arbiter_rr.sv
// Combinational round-robin winner search: lowest request at or above ptr,
// otherwise the lowest request below ptr.
module rr_arbiter #(
   parameter  int N_REQ = 2,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt_oh,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_any
);
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int j = 0; j < N_REQ; j++) begin
         if (!gnt_any && req[j] && (j >= int'(ptr))) begin
            gnt_any   = 1'b1;
            gnt_oh[j] = 1'b1;
            gnt_idx   = IDX_W'(j);
         end
      end
      for (int j = 0; j < N_REQ; j++) begin
         if (!gnt_any && req[j] && (j < int'(ptr))) begin
            gnt_any   = 1'b1;
            gnt_oh[j] = 1'b1;
            gnt_idx   = IDX_W'(j);
         end
      end
   end
endmodule

// File: rtl/repo_read_arbiter.sv
// Round-robin burst read arbiter in front of the shared task repository.
// Reads are issued back-to-back; a tag pipe matches returned words to the owner.
module repo_read_arbiter
   import hybrid_repo_pack::*;
#(
   parameter int N_REQ   = 2,
   parameter int LEN_W   = 8,
   parameter int MEM_LAT = 2,
   parameter int ADDR_W  = REPO_ADDR_W
) (
   input logic                clock,
   input logic                reset,
   repo_read_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(N_REQ);
   localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(1 << REPO_IDX_LO);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(WORD_BYTES - ADDR_W'(1));

   repo_state_t        state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;
   repo_tag_t          tag_q [MEM_LAT];
   repo_tag_t          tag_d [MEM_LAT];

   logic [N_REQ-1:0]   win_oh;
   logic [IDX_W-1:0]   win_idx;
   logic               win_any;
   logic [ADDR_W-1:0]  sel_addr;
   logic [LEN_W-1:0]   sel_len;
   logic [N_REQ-1:0]   owner_oh;
   logic [N_REQ-1:0]   gnt_o;
   logic [N_REQ-1:0]   done_o;
   logic               issue;
   repo_tag_t          tag_in;
   repo_tag_t          tag_out;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req     (bus.req),
      .ptr     (rr_ptr_q),
      .gnt_oh  (win_oh),
      .gnt_idx (win_idx),
      .gnt_any (win_any)
   );

   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      owner_oh = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (win_oh[j]) begin
            sel_addr = bus.req_addr[j*ADDR_W +: ADDR_W];
            sel_len  = bus.req_len[j*LEN_W +: LEN_W];
         end
         owner_oh[j] = (owner_q == IDX_W'(j));
      end
   end

   assign tag_out = tag_q[MEM_LAT-1];
   assign tag_in  = {issue, issue && (remaining_q == LEN_W'(1))};

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      issue       = 1'b0;
      gnt_o       = '0;
      done_o      = '0;
      case (state_q)
         IDLE: begin
            if (win_any) begin
               owner_d     = win_idx;
               cur_addr_d  = sel_addr & ALIGN_MASK;
               remaining_d = (sel_len == '0) ? LEN_W'(1) : sel_len;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            issue       = 1'b1;
            gnt_o       = owner_oh;
            cur_addr_d  = cur_addr_q + WORD_BYTES;
            remaining_d = remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) state_d = DRAIN;
         end
         DRAIN: begin
            gnt_o = owner_oh;
            if (tag_out.valid && tag_out.last) state_d = DONE;
         end
         DONE: begin
            done_o   = owner_oh;
            rr_ptr_d = (owner_q == IDX_W'(N_REQ-1)) ? '0 : owner_q + IDX_W'(1);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Tag pipe tracks the memory latency so each returned word knows if it is the last.
   always_comb begin
      tag_d[0] = tag_in;
      for (int i = 1; i < MEM_LAT; i++) tag_d[i] = tag_q[i-1];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         for (int i = 0; i < MEM_LAT; i++) tag_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         tag_q       <= tag_d;
      end
   end

   assign bus.gnt      = gnt_o;
   assign bus.done     = done_o;
   assign bus.mem_rd   = issue;
   assign bus.mem_addr = issue ? cur_addr_q : '0;
   assign bus.rvalid   = tag_out.valid ? owner_oh : '0;
   assign bus.rdata    = tag_out.valid ? bus.mem_data : '0;
endmodule

// File: tb/tb_repo_read_arbiter.sv
// Bench for repo_read_arbiter: latency-pipelined memory model, scoreboard
// queues for addresses/data/done, a vector table and hand-written corner cases.
module tb_repo_read_arbiter;
   import hybrid_repo_pack::*;

   localparam int N  = 2;
   localparam int LW = 8;
   localparam int ML = 2;
   localparam int AW = REPO_ADDR_W;

   typedef struct {
      logic [N-1:0] who;
      logic [31:0]  data;
   } exp_t;

   typedef struct {
      int           r;
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
      logic [AW-1:0] exp_a0;
      int           exp_n;
      bit           drop;
   } vec_t;

   logic clock = 1'b0;
   logic reset;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic [N*LW-1:0] req_len;
   logic [31:0]     mpipe [ML];

   int n_vec;
   int n_err;
   logic [AW-1:0] addr_q [$];
   exp_t          exp_q [$];
   logic [N-1:0]  done_q [$];
   vec_t          tbl [6];

   always #5 clock = ~clock;

   repo_read_arbiter_if #(.N_REQ(N), .LEN_W(LW), .ADDR_W(AW)) bus ();

   assign bus.req      = req;
   assign bus.req_addr = req_addr;
   assign bus.req_len  = req_len;
   assign bus.mem_data = mpipe[ML-1];

   repo_read_arbiter #(.N_REQ(N), .LEN_W(LW), .MEM_LAT(ML), .ADDR_W(AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] word_of(input logic [AW-1:0] a);
      return 32'h5A00_0000 | 32'(a[REPO_IDX_HI:REPO_IDX_LO]);
   endfunction

   // Repository model: synchronous read, data out ML cycles after the read cycle.
   always @(posedge clock) begin
      mpipe[0] <= bus.mem_rd ? word_of(bus.mem_addr) : 32'hDEAD_BEEF;
      for (int i = 1; i < ML; i++) mpipe[i] <= mpipe[i-1];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_burst(input int r, input logic [AW-1:0] a0, input int n);
      logic [AW-1:0] a;
      a = a0;
      for (int k = 0; k < n; k++) begin
         addr_q.push_back(a);
         exp_q.push_back('{who: N'(1 << r), data: word_of(a)});
         a = a + AW'(4);
      end
      done_q.push_back(N'(1 << r));
   endtask

   task automatic flush_queues();
      addr_q.delete();
      exp_q.delete();
      done_q.delete();
   endtask

   task automatic wait_done(input int r, input int budget);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clock);
         if (bus.done[r]) begin
            seen   = 1'b1;
            req[r] = 1'b0;
         end
      end
      check("done_wait", 64'(seen), 64'd1);
   endtask

   task automatic wait_gnt(input int r, input int budget);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clock);
         if (bus.gnt[r]) seen = 1'b1;
      end
      check("gnt_wait", 64'(seen), 64'd1);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            check("rst_outputs", 64'({bus.gnt, bus.rvalid, bus.done, bus.mem_rd}), 64'd0);
         end else begin
            check("gnt_onehot0", 64'($onehot0(bus.gnt)), 64'd1);
            if (|bus.rvalid) begin
               if (exp_q.size() == 0) check("rvalid_unexpected", 64'(bus.rvalid), 64'd0);
               else begin
                  e = exp_q.pop_front();
                  check("rvalid_owner", 64'(bus.rvalid), 64'(e.who));
                  check("rdata", 64'(bus.rdata), 64'(e.data));
               end
            end else begin
               check("rdata_idle", 64'(bus.rdata), 64'd0);
            end
            if (bus.mem_rd) begin
               if (addr_q.size() == 0) check("mem_rd_unexpected", 64'(bus.mem_rd), 64'd0);
               else check("mem_addr", 64'(bus.mem_addr), 64'(addr_q.pop_front()));
            end
            if (|bus.done) begin
               if (done_q.size() == 0) check("done_unexpected", 64'(bus.done), 64'd0);
               else check("done_owner", 64'(bus.done), 64'(done_q.pop_front()));
            end
         end
      end
   endtask

   initial begin
      tbl[0] = '{1, 30'h0000_0200, 8'd4,   30'h0000_0200, 4,   1'b0};
      tbl[1] = '{0, 30'h3FFF_FFFE, 8'd2,   30'h3FFF_FFFC, 2,   1'b0};
      tbl[2] = '{1, 30'h0000_1007, 8'd0,   30'h0000_1004, 1,   1'b1};
      tbl[3] = '{0, 30'h0000_0F00, 8'd3,   30'h0000_0F00, 3,   1'b0};
      tbl[4] = '{1, 30'h0123_4560, 8'd5,   30'h0123_4560, 5,   1'b1};
      tbl[5] = '{0, 30'h0000_0040, 8'd255, 30'h0000_0040, 255, 1'b0};

      n_vec    = 0;
      n_err    = 0;
      reset    = 1'b0;
      req      = 2'b11;
      req_addr = '0;
      req_len  = '0;
      fork
         monitor();
      join_none

      // Reset held with both requests pending.
      repeat (3) @(negedge clock);
      check("rst_gnt", 64'(bus.gnt), 64'd0);
      check("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
      check("rst_rvalid", 64'(bus.rvalid), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      req = '0;
      @(negedge clock);
      reset = 1'b1;

      // Single-word latency.
      @(negedge clock);
      req_addr[0 +: AW] = 30'h100;
      req_len[0 +: LW]  = 8'd1;
      req               = 2'b01;
      push_burst(0, 30'h100, 1);
      @(negedge clock);
      check("lat_gnt", 64'(bus.gnt), 64'd1);
      check("lat_mem_rd", 64'(bus.mem_rd), 64'd1);
      check("lat_mem_addr", 64'(bus.mem_addr), 64'h100);
      @(negedge clock);
      check("lat_mem_rd_off", 64'(bus.mem_rd), 64'd0);
      check("lat_rvalid_early", 64'(bus.rvalid), 64'd0);
      @(negedge clock);
      check("lat_rvalid", 64'(bus.rvalid), 64'd1);
      check("lat_rdata", 64'(bus.rdata), 64'h5A00_0040);
      @(negedge clock);
      check("lat_done", 64'(bus.done), 64'd1);
      check("lat_gnt_off", 64'(bus.gnt), 64'd0);
      req = '0;
      @(negedge clock);
      check("lat_done_pulse", 64'(bus.done), 64'd0);

      // Table of single-requester bursts; inputs scrambled after the grant.
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         push_burst(tbl[i].r, tbl[i].exp_a0, tbl[i].exp_n);
         req_addr[tbl[i].r*AW +: AW] = tbl[i].addr;
         req_len[tbl[i].r*LW +: LW]  = tbl[i].len;
         req[tbl[i].r]               = 1'b1;
         wait_gnt(tbl[i].r, 10);
         req_addr[tbl[i].r*AW +: AW] = AW'($urandom);
         req_len[tbl[i].r*LW +: LW]  = LW'($urandom);
         if (tbl[i].drop) req[tbl[i].r] = 1'b0;
         wait_done(tbl[i].r, 400);
         @(negedge clock);
         check("vec_words_left", 64'(exp_q.size()), 64'd0);
      end

      // Contention from reset, then a re-request during the other owner's burst.
      @(negedge clock);
      reset = 1'b0;
      req   = '0;
      flush_queues();
      repeat (2) @(negedge clock);
      req_addr = {30'h400, 30'h300};
      req_len  = {8'd2, 8'd2};
      req      = 2'b11;
      push_burst(0, 30'h300, 2);
      push_burst(1, 30'h400, 2);
      @(negedge clock);
      reset = 1'b1;
      wait_done(0, 20);
      wait_gnt(1, 10);
      req_addr[0 +: AW] = 30'h500;
      req_len[0 +: LW]  = 8'd1;
      req[0]            = 1'b1;
      push_burst(0, 30'h500, 1);
      wait_done(1, 20);
      wait_done(0, 20);

      // Abort a long burst during its third issue.
      @(negedge clock);
      req_addr[0 +: AW] = 30'h800;
      req_len[0 +: LW]  = 8'd8;
      req               = 2'b01;
      push_burst(0, 30'h800, 8);
      begin
         bit seen;
         seen = 1'b0;
         for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            if (bus.mem_rd && bus.mem_addr == 30'h808) seen = 1'b1;
         end
         check("abort_reach", 64'(seen), 64'd1);
      end
      #2 reset = 1'b0;
      #1;
      check("abort_gnt", 64'(bus.gnt), 64'd0);
      check("abort_mem_rd", 64'(bus.mem_rd), 64'd0);
      check("abort_rvalid", 64'(bus.rvalid), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_mem_addr", 64'(bus.mem_addr), 64'd0);
      flush_queues();
      req      = '0;
      req_addr = {30'hA00, 30'h900};
      req_len  = {8'd1, 8'd1};
      @(negedge clock);
      reset = 1'b1;
      req   = 2'b11;
      push_burst(0, 30'h900, 1);
      push_burst(1, 30'hA00, 1);
      #1;
      check("abort_inflight_rvalid", 64'(bus.rvalid), 64'd0);
      check("abort_inflight_rdata", 64'(bus.rdata), 64'd0);
      wait_done(0, 20);
      wait_done(1, 20);

      repeat (4) @(negedge clock);
      check("left_addr", 64'(addr_q.size()), 64'd0);
      check("left_data", 64'(exp_q.size()), 64'd0);
      check("left_done", 64'(done_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
